segment_display_arbiter: RTL
============================

# segment_display_arbiter

Time-shares the board's six-digit seven-segment display between up to NUM_SOURCES requesters (e.g. SDRAM address, write count, error count). Rotates round-robin over valid sources with a fixed dwell and blank gap. Converts the selected binary value to BCD with a sequential double-dabble engine in place of a combinational divide/modulo chain. Outputs feed the six per-digit SevenSegmentDisplay decoders.

## Interface
- NUM_SOURCES, 4: requester count (1..8).
- DATA_WIDTH, 20: requester value width; 20 covers 999999.
- DWELL_CYCLES, 100000000: cycles one source is shown (2 s at 50 MHz).
- BLANK_CYCLES, 10000000: blank gap between different sources.
- REFRESH_CYCLES, 5000000: re-sample/re-convert period of the shown source during dwell.
- Clock: clock_50Mhz; reset: reset_n, synchronous and active-low.
- clock_50Mhz  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_SOURCES  source has a value to show (level).
- req_value  in  NUM_SOURCES x DATA_WIDTH  binary value per source.
- bcd_digits  out  6 x 4  BCD digit, index 0 = least significant.
- digit_blank  out  6  per-digit blank request to decoder.
- active_source  out  $clog2(NUM_SOURCES) (min 1)  source currently shown.
- overflow  out  1  shown value exceeded 999999 (saturated).
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SELECT, CONVERT, SHOW, GAP.
- IDLE: all digit_blank=1. Any req_valid -> SELECT.
- SELECT (1 cycle): pick first valid source searching from last_source+1 with wrap. Snapshot its req_value. None valid -> IDLE.
- CONVERT: DATA_WIDTH cycles of shift-and-add-3. Shadow BCD register only; outputs unchanged until done.
- On completion, go to SHOW and commit bcd_digits, overflow and active_source in the same cycle.
- Snapshot > 999999: bcd_digits = 9,9,9,9,9,9 and overflow=1.
- SHOW: dwell counter runs. Every REFRESH_CYCLES, re-snapshot the same source and run CONVERT (dwell counter keeps running), then return to SHOW.
- Dwell expiry: another source valid -> GAP. Only the current source valid -> SELECT directly (no gap, no blank flicker).
- Current source drops req_valid during SHOW or CONVERT: abort immediately -> GAP.
- GAP: all digit_blank=1 for BLANK_CYCLES, then SELECT.
- Reset in any state: discard the conversion; next start begins at source 0.

## Timing
- Reset values: bcd_digits=0, digit_blank=6'b111111, active_source=0, overflow=0, busy=0, last_source=NUM_SOURCES-1.
- req_valid rising in IDLE -> SELECT next cycle.
- Outputs valid DATA_WIDTH+2 cycles after the req_valid edge (21 + 1 for defaults).
- Dwell is measured from the first SHOW entry. Refresh conversions do not extend it.
- Counters saturate-free: each clears on state entry. Widths come from $clog2 of the largest parameter.
- Simultaneous dwell expiry and refresh tick: expiry wins.
- Valid drop and expiry in the same cycle: treat as a drop (-> GAP).

## Configuration
- LEADING_ZERO_BLANK_EN defined: in SHOW, digit_blank[i]=1 for every zero digit above the most significant non-zero digit. Digit 0 is never blanked, so 0 shows as a single "0".
- Undefined: digit_blank=0 for all digits in SHOW, and leading zeros are displayed.
- Blanking in IDLE and GAP is identical in both builds.

## Structure
- Package segment_display_pkg holds:
  - the state enum (IDLE, SELECT, CONVERT, SHOW, GAP);
  - NUM_DIGITS=6 and MAX_DISPLAY=999999;
  - typedef bcd_digit_t (logic [3:0]).
- Sub-module bin_to_bcd_seq: start/done handshake. One start pulse gives done exactly DATA_WIDTH cycles later. It holds the result until the next start and does saturation internally.
- Top level holds the arbiter FSM, counters and the output registers.

## Test plan
Bench uses DWELL_CYCLES=100, BLANK_CYCLES=10, REFRESH_CYCLES=30, DATA_WIDTH=20.
- Reset with req_valid=0 -> digit_blank=111111, busy=0, bcd_digits all 0.
- Single source 0, value 123456 -> after 22 cycles digits 1,2,3,4,5,6, active_source=0. At dwell expiry, re-selects source 0 with no blank cycles.
- Sources 1 and 3 valid (42, 999999) -> shows 1, then 10 blank cycles, then 3, then 1. Source 3 shows overflow=0. Set value 1000000 -> 999999 and overflow=1.
- Source 2 value changes 500 -> 501 mid-dwell -> display updates within 30+20 cycles, and the dwell end time is unchanged.
- Source drops req_valid mid-CONVERT -> outputs untouched, GAP entered next cycle. Reset asserted mid-SHOW -> reset values on the next edge.
- Value 7 with LEADING_ZERO_BLANK_EN -> digit_blank=111110. Without the macro -> 000000.

Source files
------------

// File: rtl/segment_display_pkg.sv
// Shared types and constants for the segment display arbiter and its BCD converter.
package segment_display_pkg;

    localparam int NUM_DIGITS  = 6;
    localparam int MAX_DISPLAY = 999999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CONVERT = 3'd2,
        SHOW    = 3'd3,
        GAP     = 3'd4
    } state_t;

    function automatic bcd_digit_t dabble_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Digit 0 always stays lit so a zero value still shows a single "0".
    function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [NUM_DIGITS*4-1:0] digits);
        logic [NUM_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen    = seen | (digits[i*4 +: 4] != 4'd0);
            mask[i] = ~seen;
        end
        return mask;
    endfunction

endpackage

// File: rtl/segment_display_arbiter_bin_to_bcd.sv
// Sequential double-dabble converter: one input bit per cycle, done exactly DATA_WIDTH
// cycles after start; result (saturated to 999999) is held until the next start.
module bin_to_bcd_seq
    import segment_display_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [DATA_WIDTH-1:0]   i_value,
    output logic                    o_done,
    output logic [NUM_DIGITS*4-1:0] o_bcd,
    output logic                    o_overflow
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int CMP_W = (DATA_WIDTH > 20) ? DATA_WIDTH : 20;
    localparam int BCD_W = NUM_DIGITS * 4;

    logic [DATA_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]      r_bcd;
    logic [BCD_W-1:0]      w_adj;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_run;
    logic                  r_sat;
    logic                  r_done;

    // Add-3 correction on every nibble ahead of the shift.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_adj[i*4 +: 4] = dabble_adjust(r_bcd[i*4 +: 4]);
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_sat  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_bin  <= i_value;
            r_bcd  <= '0;
            r_cnt  <= CNT_W'(DATA_WIDTH);
            r_run  <= 1'b1;
            r_sat  <= (CMP_W'(i_value) > CMP_W'(MAX_DISPLAY));
            r_done <= 1'b0;
        end else if (r_run) begin
            r_bcd  <= {w_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
            r_bin  <= r_bin << 1;
            r_cnt  <= r_cnt - CNT_W'(1);
            r_run  <= (r_cnt != CNT_W'(1));
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done     = r_done;
    assign o_overflow = r_sat;
    assign o_bcd      = r_sat ? {NUM_DIGITS{4'd9}} : r_bcd;

endmodule

// File: rtl/segment_display_arbiter.sv
// Round-robin time-sharing of the six-digit display between requesters, with dwell, refresh
// and blank gap. Build option LEADING_ZERO_BLANK_EN blanks leading zero digits while showing.
module segment_display_arbiter
    import segment_display_pkg::*;
#(
    parameter  int NUM_SOURCES    = 4,
    parameter  int DATA_WIDTH     = 20,
    parameter  int DWELL_CYCLES   = 100000000,
    parameter  int BLANK_CYCLES   = 10000000,
    parameter  int REFRESH_CYCLES = 5000000,
    localparam int SRC_W          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                                  clock_50Mhz,
    input  logic                                  reset_n,
    input  logic [NUM_SOURCES-1:0]                req_valid,
    input  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] req_value,
    output bcd_digit_t [NUM_DIGITS-1:0]           bcd_digits,
    output logic [NUM_DIGITS-1:0]                 digit_blank,
    output logic [SRC_W-1:0]                      active_source,
    output logic                                  overflow,
    output logic                                  busy
);
    localparam int MAX_CYC_A = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int MAX_CYC   = (MAX_CYC_A > REFRESH_CYCLES) ? MAX_CYC_A : REFRESH_CYCLES;
    localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [SRC_W-1:0]         r_cur_src;
    logic [SRC_W-1:0]         r_last_src;
    logic                     r_refresh;
    logic [CNT_W-1:0]         r_timer;
    logic [CNT_W-1:0]         r_dwell;

    logic [SRC_W-1:0]         w_idx;
    logic [SRC_W-1:0]         w_sel_src;
    logic                     w_sel_found;
    logic                     w_cur_valid;
    logic                     w_other_valid;
    logic                     w_dwell_done;
    logic                     w_refresh_tick;
    logic                     w_commit;
    logic                     w_start;
    logic [SRC_W-1:0]         w_start_src;
    logic                     w_conv_done;
    logic                     w_conv_ovf;
    logic [NUM_DIGITS*4-1:0]  w_conv_bcd;
    logic [NUM_DIGITS-1:0]    w_show_blank;

    bin_to_bcd_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bin_to_bcd (
        .i_clk      (clock_50Mhz),
        .i_rst_n    (reset_n),
        .i_start    (w_start),
        .i_value    (req_value[w_start_src]),
        .o_done     (w_conv_done),
        .o_bcd      (w_conv_bcd),
        .o_overflow (w_conv_ovf)
    );

    // Round-robin search starting one past the last source shown; lowest offset wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_src   = '0;
        w_idx       = '0;
        for (int k = NUM_SOURCES; k >= 1; k--) begin
            w_idx       = SRC_W'((int'(r_last_src) + k) % NUM_SOURCES);
            w_sel_src   = req_valid[w_idx] ? w_idx : w_sel_src;
            w_sel_found = w_sel_found | req_valid[w_idx];
        end
    end

    assign w_cur_valid    = req_valid[r_cur_src];
    assign w_other_valid  = |(req_valid & ~(NUM_SOURCES'(1'b1) << r_cur_src));
    assign w_dwell_done   = (r_dwell == DWELL_LAST) &&
                            ((r_state == SHOW) || ((r_state == CONVERT) && r_refresh));
    assign w_refresh_tick = (r_state == SHOW) && (r_timer == REFRESH_LAST);
    assign w_commit       = (r_state == CONVERT) && (w_next_state == SHOW);

    // Blanking applied when a fresh conversion is committed to the display.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        w_show_blank = leading_zero_mask(w_conv_bcd);
`else
        w_show_blank = '0;
`endif
    end

    // Next-state logic; a valid drop outranks dwell expiry, which outranks refresh.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_start_src  = r_cur_src;
        case (r_state)
            IDLE: begin
                if (|req_valid) w_next_state = SELECT;
                else            w_next_state = IDLE;
            end
            SELECT: begin
                if (w_sel_found) begin
                    w_next_state = CONVERT;
                    w_start      = 1'b1;
                    w_start_src  = w_sel_src;
                end else begin
                    w_next_state = IDLE;
                end
            end
            CONVERT: begin
                if (!w_cur_valid)      w_next_state = GAP;
                else if (w_dwell_done) w_next_state = w_other_valid ? GAP : SELECT;
                else if (w_conv_done)  w_next_state = SHOW;
                else                   w_next_state = CONVERT;
            end
            SHOW: begin
                if (!w_cur_valid) begin
                    w_next_state = GAP;
                end else if (w_dwell_done) begin
                    w_next_state = w_other_valid ? GAP : SELECT;
                end else if (w_refresh_tick) begin
                    w_next_state = CONVERT;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = SHOW;
                end
            end
            GAP: begin
                if (r_timer == BLANK_LAST) w_next_state = SELECT;
                else                       w_next_state = GAP;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register plus source bookkeeping.
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cur_src  <= '0;
            r_last_src <= SRC_W'(NUM_SOURCES - 1);
            r_refresh  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == SELECT) && w_sel_found) begin
                r_cur_src  <= w_sel_src;
                r_last_src <= w_sel_src;
                r_refresh  <= 1'b0;
            end else if ((r_state == SHOW) && (w_next_state == CONVERT)) begin
                r_refresh <= 1'b1;
            end else begin
                r_refresh <= r_refresh;
            end
        end
    end

    // Gap/refresh timer restarts on every state change; dwell keeps running through refreshes.
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            r_timer <= '0;
            r_dwell <= '0;
        end else begin
            if ((w_next_state == r_state) && ((r_state == SHOW) || (r_state == GAP))) begin
                r_timer <= r_timer + CNT_W'(1);
            end else begin
                r_timer <= '0;
            end
            if (w_commit && !r_refresh) begin
                r_dwell <= '0;
            end else if (((r_state == SHOW) || ((r_state == CONVERT) && r_refresh)) &&
                         (r_dwell != DWELL_LAST)) begin
                r_dwell <= r_dwell + CNT_W'(1);
            end else begin
                r_dwell <= r_dwell;
            end
        end
    end

    // Display outputs change only on commit, or blank on entry to IDLE/GAP.
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            bcd_digits    <= '0;
            digit_blank   <= '1;
            active_source <= '0;
            overflow      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            busy <= (w_next_state != IDLE);
            if ((w_next_state == IDLE) || (w_next_state == GAP)) begin
                digit_blank <= '1;
            end else if (w_commit) begin
                digit_blank   <= w_show_blank;
                bcd_digits    <= w_conv_bcd;
                overflow      <= w_conv_ovf;
                active_source <= r_cur_src;
            end else begin
                digit_blank <= digit_blank;
            end
        end
    end

endmodule
